// File: rtl/pwm_multi_scheduler.sv
// Round-robin pulse-width scheduler: one shared width counter measures each PWM
// input in turn and keeps a hysteresis on/off decision and a timeout flag per channel.
//
// state     | meaning
// IDLE      | scheduler disabled, outputs held
// ARM       | wait for the selected input to be low (rejects a pulse already in progress)
// WAIT_RISE | wait for the rising edge of the selected input
// MEASURE   | count synchronized high cycles, saturating at MAX
// EVAL      | apply thresholds, publish width, advance to the next channel
module pwm_multi_scheduler #(
    parameter int NUM_CHANNELS       = 4,
    parameter int MAX_COUNTER_VALUE  = 2000,
    parameter int HIGH_COUNTER_VALUE = 1750,
    parameter int LOW_COUNTER_VALUE  = 1250,
    parameter int TIMEOUT_VALUE      = 5000
) (
    input  logic                                         clock_i,
    input  logic                                         reset_i,
    input  logic                                         enable_i,
    input  logic [NUM_CHANNELS-1:0]                      pwm_i,
    output logic [NUM_CHANNELS-1:0]                      output_pins_o,
    output logic [NUM_CHANNELS-1:0]                      timeout_o,
    output logic [$clog2(MAX_COUNTER_VALUE+1)-1:0]       width_o,
    output logic [$clog2(NUM_CHANNELS)-1:0]              done_channel_o,
    output logic                                         done_o,
    output logic                                         busy_o
);

    localparam int CW = $clog2(MAX_COUNTER_VALUE + 1);
    localparam int TW = $clog2(TIMEOUT_VALUE + 1);
    localparam int SW = $clog2(NUM_CHANNELS);

    localparam logic [CW-1:0] MAX_W  = CW'(MAX_COUNTER_VALUE);
    localparam logic [CW-1:0] HIGH_W = CW'(HIGH_COUNTER_VALUE);
    localparam logic [CW-1:0] LOW_W  = CW'(LOW_COUNTER_VALUE);
    localparam logic [TW-1:0] TO_W   = TW'(TIMEOUT_VALUE);
    localparam logic [SW-1:0] LAST_SEL = SW'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RISE,
        MEASURE,
        EVAL
    } state_t;

    state_t state, state_next;

    logic [NUM_CHANNELS-1:0] sync_1, sync_2;
    logic [SW-1:0]           sel, sel_next, sel_inc;
    logic [CW-1:0]           cnt, cnt_next;
    logic [TW-1:0]           tcnt, tcnt_next;
    logic [NUM_CHANNELS-1:0] pins_next, to_next;
    logic [CW-1:0]           width_next;
    logic [SW-1:0]           dch_next;
    logic                    done_next;
    logic                    cur;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= pwm_i;
            sync_2 <= sync_1;
        end
    end

    assign cur     = sync_2[sel];
    assign sel_inc = (sel == LAST_SEL) ? '0 : sel + 1'b1;
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        cnt_next   = cnt;
        tcnt_next  = tcnt;
        pins_next  = output_pins_o;
        to_next    = timeout_o;
        width_next = width_o;
        dch_next   = done_channel_o;
        done_next  = 1'b0;

        // Dropping enable abandons any measurement; published results stay put.
        if (!enable_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ARM;
                    sel_next   = '0;
                    tcnt_next  = '0;
                end
                ARM, WAIT_RISE: begin
                    if (tcnt == TO_W) begin
                        to_next[sel] = 1'b1;
                        sel_next     = sel_inc;
                        tcnt_next    = '0;
                        state_next   = ARM;
                    end else begin
                        tcnt_next = tcnt + 1'b1;
                        if (state == ARM && !cur) begin
                            state_next = WAIT_RISE;
                        end else if (state == WAIT_RISE && cur) begin
                            state_next = MEASURE;
                            cnt_next   = CW'(1);
                        end
                    end
                end
                MEASURE: begin
                    if (!cur || cnt == MAX_W) begin
                        state_next = EVAL;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (cnt > HIGH_W) begin
                        pins_next[sel] = 1'b1;
                    end else if (cnt < LOW_W) begin
                        pins_next[sel] = 1'b0;
                    end
                    to_next[sel] = 1'b0;
                    width_next   = cnt;
                    dch_next     = sel;
                    done_next    = 1'b1;
                    sel_next     = sel_inc;
                    tcnt_next    = '0;
                    state_next   = ARM;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sel            <= '0;
            cnt            <= '0;
            tcnt           <= '0;
            output_pins_o  <= '0;
            timeout_o      <= '0;
            width_o        <= '0;
            done_channel_o <= '0;
            done_o         <= 1'b0;
        end else begin
            sel            <= sel_next;
            cnt            <= cnt_next;
            tcnt           <= tcnt_next;
            output_pins_o  <= pins_next;
            timeout_o      <= to_next;
            width_o        <= width_next;
            done_channel_o <= dch_next;
            done_o         <= done_next;
        end
    end

endmodule

// File: tb/tb_pwm_multi_scheduler.sv
// Directed bench for pwm_multi_scheduler: walks the round-robin through set,
// hysteresis, timeout, partial pulse, saturation, disable and reset scenarios.
module tb_pwm_multi_scheduler;

    logic        clock_i;
    logic        reset_i;
    logic        enable_i;
    logic [3:0]  pwm_i;
    logic [3:0]  output_pins_o;
    logic [3:0]  timeout_o;
    logic [10:0] width_o;
    logic [1:0]  done_channel_o;
    logic        done_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_multi_scheduler #(
        .NUM_CHANNELS       (4),
        .MAX_COUNTER_VALUE  (2000),
        .HIGH_COUNTER_VALUE (1750),
        .LOW_COUNTER_VALUE  (1250),
        .TIMEOUT_VALUE      (5000)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .pwm_i          (pwm_i),
        .output_pins_o  (output_pins_o),
        .timeout_o      (timeout_o),
        .width_o        (width_o),
        .done_channel_o (done_channel_o),
        .done_o         (done_o),
        .busy_o         (busy_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse channel ch for h clocks; the fall is sampled at edge k, results must
    // appear after edge k+3 and done_o must drop again after k+4.
    task automatic pulse_and_check(input string name, input int ch, input int h,
                                   input logic [10:0] exp_w, input logic [3:0] exp_pins,
                                   input logic [3:0] exp_to);
        repeat (4) @(negedge clock_i);
        pwm_i[ch] = 1'b1;
        repeat (h) @(negedge clock_i);
        pwm_i[ch] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_i); #1;
            n_tests++;
            if (done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early_done at k+%0d: done_o=%b required 0", name, i, done_o);
            end
        end
        @(posedge clock_i); #1;
        n_tests++;
        if ({done_o, width_o, done_channel_o, output_pins_o, timeout_o} !==
            {1'b1, exp_w, 2'(ch), exp_pins, exp_to}) begin
            n_fail++;
            $display("FAIL %s result: done=%b width=%0d ch=%0d pins=%b to=%b required done=1 width=%0d ch=%0d pins=%b to=%b",
                     name, done_o, width_o, done_channel_o, output_pins_o, timeout_o,
                     exp_w, ch, exp_pins, exp_to);
        end
        @(posedge clock_i); #1;
        n_tests++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: done_o=%b one cycle later, required 0", name, done_o);
        end
    endtask

    task automatic test_reset();
        reset_i  = 1'b0;
        enable_i = 1'b0;
        pwm_i    = 4'b0000;
        repeat (3) @(negedge clock_i);
        n_tests++;
        if ({output_pins_o, timeout_o, width_o, done_channel_o, done_o, busy_o} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_initial: pins=%b to=%b width=%0d ch=%0d done=%b busy=%b required all 0",
                     output_pins_o, timeout_o, width_o, done_channel_o, done_o, busy_o);
        end
        reset_i  = 1'b1;
        enable_i = 1'b1;
        @(posedge clock_i); #1;
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_busy: busy_o=%b required 1", busy_o);
        end
        @(negedge clock_i);
        pwm_i[0] = 1'b1;
        repeat (20) @(negedge clock_i);
        #2 reset_i = 1'b0;
        #1;
        n_tests++;
        if ({output_pins_o, timeout_o, width_o, done_channel_o, done_o, busy_o} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_mid_measure: pins=%b to=%b width=%0d ch=%0d done=%b busy=%b required all 0",
                     output_pins_o, timeout_o, width_o, done_channel_o, done_o, busy_o);
        end
        @(negedge clock_i);
        pwm_i[0] = 1'b0;
        repeat (2) @(negedge clock_i);
        reset_i = 1'b1;
        @(posedge clock_i); #1;
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rearm_busy: busy_o=%b required 1", busy_o);
        end
    endtask

    task automatic test_set_threshold();
        pulse_and_check("set_ch0", 0, 1800, 11'd1800, 4'b0001, 4'b0000);
    endtask

    task automatic test_timeout();
        int n;
        // Channel 2 goes high now so it is mid-pulse when it gets selected.
        @(negedge clock_i);
        pwm_i[2] = 1'b1;
        n = 0;
        while (timeout_o[1] !== 1'b1 && n < 5200) begin
            @(posedge clock_i); #1;
            n++;
        end
        // ARM was entered one edge before counting began.
        n_tests++;
        if (n < 4999 || n > 5001) begin
            n_fail++;
            $display("FAIL timeout_delay: timeout_o[1] after %0d edges, required 4999..5001", n);
        end
        n_tests++;
        if ({timeout_o, output_pins_o} !== {4'b0010, 4'b0001}) begin
            n_fail++;
            $display("FAIL timeout_flags: to=%b pins=%b required to=0010 pins=0001", timeout_o, output_pins_o);
        end
    endtask

    task automatic test_partial_pulse();
        logic seen;
        seen = 1'b0;
        repeat (300) begin
            @(posedge clock_i); #1;
            if (done_o !== 1'b0 || busy_o !== 1'b1) seen = 1'b1;
        end
        @(negedge clock_i);
        pwm_i[2] = 1'b0;
        repeat (10) begin
            @(posedge clock_i); #1;
            if (done_o !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_no_measure: done/busy misbehaved while partial pulse active, flag=%b required 0", seen);
        end
        pulse_and_check("partial_ch2", 2, 1300, 11'd1300, 4'b0001, 4'b0010);
    endtask

    task automatic test_saturation();
        int n;
        repeat (4) @(negedge clock_i);
        pwm_i[3] = 1'b1;
        n = 0;
        while (done_o !== 1'b1 && n < 2600) begin
            @(posedge clock_i); #1;
            n++;
        end
        // 2 sync edges + 2000 counting edges + EVAL edge + done edge
        n_tests++;
        if (n != 2004) begin
            n_fail++;
            $display("FAIL sat_latency: done after %0d edges, required 2004", n);
        end
        n_tests++;
        if ({width_o, done_channel_o, output_pins_o, timeout_o} !== {11'd2000, 2'd3, 4'b1001, 4'b0010}) begin
            n_fail++;
            $display("FAIL sat_result: width=%0d ch=%0d pins=%b to=%b required width=2000 ch=3 pins=1001 to=0010",
                     width_o, done_channel_o, output_pins_o, timeout_o);
        end
        repeat (2500 - n) @(negedge clock_i);
        pwm_i[3] = 1'b0;
    endtask

    task automatic test_hysteresis();
        pulse_and_check("hyst_hold_ch0", 0, 1500, 11'd1500, 4'b1001, 4'b0010);
        pulse_and_check("timeout_clear_ch1", 1, 1600, 11'd1600, 4'b1001, 4'b0000);
        pulse_and_check("low_ch2", 2, 1000, 11'd1000, 4'b1001, 4'b0000);
    endtask

    task automatic test_disable();
        logic seen;
        repeat (4) @(negedge clock_i);
        pwm_i[3] = 1'b1;
        repeat (100) @(negedge clock_i);
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_pre_busy: busy_o=%b required 1", busy_o);
        end
        enable_i = 1'b0;
        @(posedge clock_i); #1;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_idle: busy_o=%b one edge after disable, required 0", busy_o);
        end
        @(negedge clock_i);
        pwm_i[3] = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clock_i); #1;
            if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_quiet: done/busy activity while disabled, flag=%b required 0", seen);
        end
        n_tests++;
        if ({output_pins_o, timeout_o, width_o, done_channel_o} !== {4'b1001, 4'b0000, 11'd1000, 2'd2}) begin
            n_fail++;
            $display("FAIL disable_hold: pins=%b to=%b width=%0d ch=%0d required pins=1001 to=0000 width=1000 ch=2",
                     output_pins_o, timeout_o, width_o, done_channel_o);
        end
        @(negedge clock_i);
        enable_i = 1'b1;
        pulse_and_check("restart_clear_ch0", 0, 1000, 11'd1000, 4'b1000, 4'b0000);
    endtask

    task automatic test_reset_late();
        @(negedge clock_i);
        pwm_i[1] = 1'b1;
        repeat (50) @(negedge clock_i);
        #2 reset_i = 1'b0;
        #1;
        n_tests++;
        if ({output_pins_o, timeout_o, width_o, done_channel_o, done_o, busy_o} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_late: pins=%b to=%b width=%0d ch=%0d done=%b busy=%b required all 0",
                     output_pins_o, timeout_o, width_o, done_channel_o, done_o, busy_o);
        end
        @(negedge clock_i);
        pwm_i = 4'b0000;
        reset_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_set_threshold();
        test_timeout();
        test_partial_pulse();
        test_saturation();
        test_hysteresis();
        test_disable();
        test_reset_late();
        repeat (5) @(negedge clock_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi_scheduler.md
# pwm_multi_scheduler

Round-robin controller that shares one pulse-width measurement datapath among `NUM_CHANNELS` PWM inputs. It sequences the measurement of each input, compares every captured on-time against hysteresis thresholds, and keeps one decision bit per channel. A silent or stuck channel is skipped through a timeout. The block sits between the board-level PWM receiver pins and the logic that consumes per-channel on/off decisions.

## Interface
- `NUM_CHANNELS`, 4: number of PWM inputs; must be ≥ 2.
- `MAX_COUNTER_VALUE`, 2000: on-time saturation limit, in clocks.
- `HIGH_COUNTER_VALUE`, 1750: width strictly greater than this value sets the channel output.
- `LOW_COUNTER_VALUE`, 1250: width strictly less than this value clears the channel output. Requires LOW ≤ HIGH ≤ MAX.
- `TIMEOUT_VALUE`, 5000: maximum clocks spent waiting for a clean low-to-high edge.
- `clock_i` in 1: the single clock; all logic on the rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `enable_i` in 1: scheduler run enable.
- `pwm_i` in NUM_CHANNELS: asynchronous PWM inputs.
- `output_pins_o` out NUM_CHANNELS: per-channel hysteresis decision.
- `timeout_o` out NUM_CHANNELS: sticky per-channel timeout flag.
- `width_o` out $clog2(MAX_COUNTER_VALUE+1): last valid measured width.
- `done_channel_o` out $clog2(NUM_CHANNELS): channel index belonging to `width_o`.
- `done_o` out 1: one-cycle pulse when `width_o` and `done_channel_o` update.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- Each `pwm_i` bit passes through a 2-flop synchronizer. The FSM sees only the second stage, called `s`. `sel` is the current channel index.
- IDLE:
  - Wait for `enable_i`=1, then go to ARM with `sel`=0.
  - The timeout counter clears on every entry to ARM.
- ARM: wait for `s[sel]`=0, then go to WAIT_RISE. This rejects a pulse that is already in progress.
- WAIT_RISE: on `s[sel]`=1, go to MEASURE and load the width counter with 1.
- ARM and WAIT_RISE share the timeout counter.
  - When it reaches TIMEOUT_VALUE: set `timeout_o[sel]`, advance `sel`, and re-enter ARM.
  - `output_pins_o[sel]` is held.
- MEASURE:
  - While `s[sel]`=1 and the counter is below MAX, the counter increments.
  - On `s[sel]`=0, or when the counter equals MAX, go to EVAL. The measured width W is the count of synchronized high cycles, saturated at MAX.
- EVAL takes one cycle:
  - If W > HIGH, set `output_pins_o[sel]`. If W < LOW, clear it. Otherwise hold it.
  - Load `width_o`=W and `done_channel_o`=`sel`, pulse `done_o`, and clear `timeout_o[sel]`.
  - Then `sel` = (`sel`+1) mod NUM_CHANNELS and go to ARM.
- The width counter is $clog2(MAX+1) bits wide and never wraps. The timeout counter is $clog2(TIMEOUT_VALUE+1) bits wide.
- `enable_i`=0 in any state:
  - Go to IDLE on the next edge. A measurement in progress is discarded, and `done_o` is not pulsed.
  - All outputs except `busy_o` hold.
  - When `enable_i` rises again, scanning restarts at channel 0.
- Reset (`reset_i`=0), effective immediately at any time, including mid-measurement:
  - FSM goes to IDLE and `sel`=0.
  - Synchronizers, `output_pins_o`, `timeout_o`, `width_o`, `done_channel_o`, `done_o`, and `busy_o` all go to 0.

## Timing
- Input edge to FSM: 2 cycles.
- Falling edge of `pwm_i[sel]` first sampled at edge k: the FSM leaves MEASURE at k+2. `output_pins_o`, `width_o`, `done_channel_o` update and `done_o` goes high at k+3, for exactly one cycle.
- A pulse of H clocks, stable across the synchronizer, yields W=H for H<MAX and W=MAX for H≥MAX.
- The minimum per-channel slot is ARM→WAIT_RISE→MEASURE→EVAL, plus the pulse length.
- Channels are always visited in order 0,1,…,N-1,0. No channel is skipped except by timeout.
- A timeout takes effect on the edge where the counter equals TIMEOUT_VALUE; ARM re-entry for the next channel begins on that same edge.
- `done_o` never asserts in two consecutive cycles.

## Test plan
Bench setup: N=4, MAX=2000, HIGH=1750, LOW=1250, TIMEOUT=5000.
- **Reset:** `reset_i`=0 mid-MEASURE → all outputs 0 asynchronously; after release with `enable_i`=1, ARM on channel 0.
- **Set threshold:** channel 0 gets an 1800-cycle pulse → `done_o` pulse, `width_o`=1800, `done_channel_o`=0, `output_pins_o[0]`=1, three cycles after the fall is sampled.
- **Hysteresis:** channel 0 gets a 1500-cycle pulse → `output_pins_o[0]` stays 1. Next visit gets 1000 cycles → `output_pins_o[0]`=0, `width_o`=1000.
- **Timeout:** channel 1 held low → `timeout_o[1]`=1 after 5000 cycles in ARM/WAIT_RISE, and the FSM moves to channel 2. A later valid 1600-cycle pulse on channel 1 → `timeout_o[1]`=0, `output_pins_o[1]` unchanged.
- **Partial pulse:** channel 2 already high when selected → no measurement until it goes low. The next full 1300-cycle pulse → `width_o`=1300.
- **Saturation and disable:** channel 3 high for 2500 cycles → `width_o`=2000, `output_pins_o[3]`=1. Then `enable_i`=0 mid-MEASURE → IDLE next edge, no `done_o`, `busy_o`=0.
